// File: rtl/seq_univ_reg_rst.sv
// seq_univ_reg_rst: WIDTH-bit clocked universal register.
// Modes are hold, parallel load, shift left/right with serial fill,
// rotate left/right and modulo up/down count. There is a synchronous reset and a
// global clock enable. The terminal-count flag tc looks ahead: it is high
// when the next enabled count in the selected direction would wrap.
module seq_univ_reg_rst #(
   parameter int          WIDTH   = 8,       // register width, 2..64
   parameter logic [63:0] RST_VAL = 64'd0    // reset value, truncated to WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             tc
);

   typedef enum logic [2:0] {
      MODE_HOLD  = 3'b000,
      MODE_LOAD  = 3'b001,
      MODE_SHL   = 3'b010,
      MODE_SHR   = 3'b011,
      MODE_ROL   = 3'b100,
      MODE_ROR   = 3'b101,
      MODE_UP    = 3'b110,
      MODE_DOWN  = 3'b111
   } mode_t;

   localparam logic [WIDTH-1:0] RST_Q = RST_VAL[WIDTH-1:0];

   mode_t            mode_sel;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] shl_val;
   logic [WIDTH-1:0] shr_val;
   logic [WIDTH-1:0] rol_val;
   logic [WIDTH-1:0] ror_val;

   assign mode_sel = mode_t'(mode);

   // Per-bit neighbour selection for the shift and rotate paths; the end bits
   // take either the serial input or the wrapped-around opposite end.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         if (gi == 0) begin : g_lsb
            assign shl_val[gi] = sin_l;
            assign rol_val[gi] = q_reg[WIDTH-1];
         end else begin : g_lsb_inner
            assign shl_val[gi] = q_reg[gi-1];
            assign rol_val[gi] = q_reg[gi-1];
         end
         if (gi == WIDTH-1) begin : g_msb
            assign shr_val[gi] = sin_r;
            assign ror_val[gi] = q_reg[0];
         end else begin : g_msb_inner
            assign shr_val[gi] = q_reg[gi+1];
            assign ror_val[gi] = q_reg[gi+1];
         end
      end
   endgenerate

   // Mode-selected next state used when the register is enabled.
   always_comb begin
      q_next = q_reg;
      case (mode_sel)
         MODE_HOLD: q_next = q_reg;
         MODE_LOAD: q_next = d;
         MODE_SHL:  q_next = shl_val;
         MODE_SHR:  q_next = shr_val;
         MODE_ROL:  q_next = rol_val;
         MODE_ROR:  q_next = ror_val;
         MODE_UP:   q_next = q_reg + {{(WIDTH-1){1'b0}}, 1'b1};
         MODE_DOWN: q_next = q_reg - {{(WIDTH-1){1'b0}}, 1'b1};
         default:   q_next = q_reg;
      endcase
   end

   // State register: reset beats enable, and enable beats mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg <= RST_Q;
      end else if (en) begin
         q_reg <= q_next;
      end
   end

   // Terminal count looks at the mode and q only, independent of en.
   always_comb begin
      tc = 1'b0;
      if (mode_sel == MODE_UP) begin
         tc = &q_reg;
      end else if (mode_sel == MODE_DOWN) begin
         tc = ~|q_reg;
      end
   end

   assign q      = q_reg;
   assign sout_l = q_reg[WIDTH-1];
   assign sout_r = q_reg[0];

endmodule

// File: tb/tb_seq_univ_reg_rst.sv
// Testbench for seq_univ_reg_rst. It drives an 8-bit instance (RST_VAL=8'hA5)
// and a 2-bit instance (RST_VAL=64'h6, which truncates to 2'b10) from shared
// inputs. The driver pushes the hand-computed response of each vector into a
// scoreboard queue. A separate monitor pops that queue after every clock edge
// and compares it against the instance the vector targets.
module tb_seq_univ_reg_rst;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [2:0] mode;
   logic [7:0] d;
   logic       sin_l;
   logic       sin_r;

   logic [7:0] q8;
   logic       sl8, sr8, tc8;
   logic [1:0] q2;
   logic       sl2, sr2, tc2;

   always #5 clk = ~clk;

   seq_univ_reg_rst #(.WIDTH(8), .RST_VAL(64'hA5)) dut8 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
      .sin_l(sin_l), .sin_r(sin_r),
      .q(q8), .sout_l(sl8), .sout_r(sr8), .tc(tc8)
   );

   seq_univ_reg_rst #(.WIDTH(2), .RST_VAL(64'h6)) dut2 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d[1:0]),
      .sin_l(sin_l), .sin_r(sin_r),
      .q(q2), .sout_l(sl2), .sout_r(sr2), .tc(tc2)
   );

   typedef struct {
      bit         sel;   // 0 = 8-bit instance, 1 = 2-bit instance
      int         idx;
      logic [7:0] q;
      logic       tc;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_step   = 0;

   // Apply one vector at the falling edge and queue the response that
   // must be visible after the next rising edge.
   task automatic step(input bit sel, input logic r, input logic e,
                       input logic [2:0] m, input logic [7:0] dv,
                       input logic sl, input logic sr,
                       input logic [7:0] eq, input logic etc);
      exp_t x;
      @(negedge clk);
      rst = r; en = e; mode = m; d = dv; sin_l = sl; sin_r = sr;
      n_step++;
      x.sel = sel; x.idx = n_step; x.q = eq; x.tc = etc;
      sb_q.push_back(x);
   endtask

   // Monitor: one comparison per queued vector, sampled 1 time unit after the edge.
   initial begin : monitor
      exp_t       e;
      logic [7:0] aq;
      logic       asl, asr, atc, esl, esr;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.sel == 1'b0) begin
               aq = q8; asl = sl8; asr = sr8; atc = tc8; esl = e.q[7];
            end else begin
               aq = {6'b0, q2}; asl = sl2; asr = sr2; atc = tc2; esl = e.q[1];
            end
            esr = e.q[0];
            n_checks++;
            if (aq === e.q && asl === esl && asr === esr && atc === e.tc) begin
               n_pass++;
               $display("ok   %s step%0d q=%h sout_l=%b sout_r=%b tc=%b",
                        e.sel ? "w2" : "w8", e.idx, aq, asl, asr, atc);
            end else begin
               $display("FAIL %s step%0d got q=%h sout_l=%b sout_r=%b tc=%b required q=%h sout_l=%b sout_r=%b tc=%b",
                        e.sel ? "w2" : "w8", e.idx, aq, asl, asr, atc,
                        e.q, esl, esr, e.tc);
            end
         end
      end
   end

   initial begin : driver
      logic [7:0] shr_exp [8];
      logic [7:0] ror_exp [8];
      int         wait_cnt;
      shr_exp = '{8'h81, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
      ror_exp = '{8'h96, 8'h4B, 8'hA5, 8'hD2, 8'h69, 8'hB4, 8'h5A, 8'h2D};

      // ---------------- 8-bit instance ----------------
      // reset, load, reset during count, enable-low hold
      step(0, 1, 0, 3'b000, 8'h00, 0, 0, 8'hA5, 0);
      step(0, 0, 1, 3'b001, 8'h3C, 0, 0, 8'h3C, 0);
      step(0, 1, 1, 3'b110, 8'h00, 0, 0, 8'hA5, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 3'b001, 8'hFF, 0, 0, 8'hA5, 0);
      // shift left with 0 fill, then eight shifts right with 1 fill
      step(0, 0, 1, 3'b001, 8'h81, 0, 0, 8'h81, 0);
      step(0, 0, 1, 3'b010, 8'h00, 0, 0, 8'h02, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 1, 3'b011, 8'h00, 0, 1, shr_exp[i], 0);
      // rotate left once, then eight rotates right back to the start
      step(0, 0, 1, 3'b001, 8'h96, 0, 0, 8'h96, 0);
      step(0, 0, 1, 3'b100, 8'h00, 0, 0, 8'h2D, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 1, 3'b101, 8'h00, 0, 0, ror_exp[i], 0);
      // count wrap in both directions; tc also visible with en=0
      step(0, 0, 1, 3'b001, 8'hFE, 0, 0, 8'hFE, 0);
      step(0, 0, 1, 3'b110, 8'h00, 0, 0, 8'hFF, 1);
      step(0, 0, 1, 3'b110, 8'h00, 0, 0, 8'h00, 0);
      step(0, 0, 0, 3'b111, 8'h00, 0, 0, 8'h00, 1);
      step(0, 0, 1, 3'b111, 8'h00, 0, 0, 8'hFF, 0);
      step(0, 0, 1, 3'b000, 8'h55, 1, 1, 8'hFF, 0);
      // reset in the middle of a count, then resume from RST_VAL
      step(0, 0, 1, 3'b001, 8'h10, 0, 0, 8'h10, 0);
      step(0, 0, 1, 3'b110, 8'h00, 0, 0, 8'h11, 0);
      step(0, 0, 1, 3'b110, 8'h00, 0, 0, 8'h12, 0);
      step(0, 1, 1, 3'b110, 8'h00, 0, 0, 8'hA5, 0);
      step(0, 0, 1, 3'b110, 8'h00, 0, 0, 8'hA6, 0);
      step(0, 0, 1, 3'b110, 8'h00, 0, 0, 8'hA7, 0);
      step(0, 0, 1, 3'b111, 8'h00, 0, 0, 8'hA6, 0);
      step(0, 0, 1, 3'b010, 8'h00, 1, 0, 8'h4D, 0);

      // ---------------- 2-bit instance ----------------
      step(1, 1, 0, 3'b000, 8'h00, 0, 0, 8'h02, 0);
      step(1, 0, 1, 3'b001, 8'h01, 0, 0, 8'h01, 0);
      step(1, 0, 1, 3'b010, 8'h00, 1, 0, 8'h03, 0);
      step(1, 0, 1, 3'b010, 8'h00, 0, 0, 8'h02, 0);
      step(1, 0, 1, 3'b100, 8'h00, 0, 0, 8'h01, 0);
      step(1, 0, 1, 3'b101, 8'h00, 0, 0, 8'h02, 0);
      step(1, 0, 1, 3'b011, 8'h00, 0, 0, 8'h01, 0);
      step(1, 0, 1, 3'b011, 8'h00, 0, 1, 8'h02, 0);
      step(1, 0, 1, 3'b110, 8'h00, 0, 0, 8'h03, 1);
      step(1, 0, 1, 3'b110, 8'h00, 0, 0, 8'h00, 0);
      step(1, 0, 1, 3'b111, 8'h00, 0, 0, 8'h03, 0);
      step(1, 0, 1, 3'b111, 8'h00, 0, 0, 8'h02, 0);
      step(1, 0, 1, 3'b111, 8'h00, 0, 0, 8'h01, 0);
      step(1, 0, 1, 3'b111, 8'h00, 0, 0, 8'h00, 1);
      step(1, 0, 1, 3'b111, 8'h00, 0, 0, 8'h03, 0);
      step(1, 1, 1, 3'b111, 8'h00, 0, 0, 8'h02, 0);
      step(1, 0, 0, 3'b110, 8'h00, 0, 0, 8'h02, 0);
      step(1, 0, 1, 3'b001, 8'h03, 0, 0, 8'h03, 0);
      step(1, 0, 0, 3'b110, 8'h00, 0, 0, 8'h03, 1);

      // idle the inputs and let the monitor drain, bounded
      @(negedge clk);
      en = 1'b0; rst = 1'b0; mode = 3'b000;
      wait_cnt = 0;
      while (sb_q.size() > 0 && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (sb_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain %0d entries still queued, required 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
